mdio_master: RTL
================

Name: mdio_master

Overview:
Station-management (initiator) side of the IEEE 802.3 Clause 22 MDIO link. It takes a 32-bit management frame word from the host and generates MDC. It serialises a 32-bit preamble followed by the frame onto MDIO. For reads it releases the line at turnaround and captures 16 data bits from the PHY-side controller. It is the counterpart of the existing controller block and is paired with it in the MDIO top level and benches.

Parameters:
CLK_DIV, 2, MDC half-period in clk cycles (legal values ≥1); MDC period = 2*CLK_DIV clk.
PREAMBLE_LEN, 32, number of '1' bits sent before ST.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mdio_start  in  1  one-cycle request; sampled only in IDLE
t_data  in  32  frame word, MSB first: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA
mdio_in  in  1  serial data from PHY (read data phase)
mdc  out  1  management clock
mdio_out  out  1  serial data to PHY
mdio_oe  out  1  1 = master drives MDIO
rd_data  out  16  captured read data
mdio_done  out  1  one-cycle completion pulse
busy  out  1  transaction in progress

Behaviour:
- Reset (async, immediate) forces all outputs to 0: mdc, mdio_out, mdio_oe, rd_data, mdio_done and busy. The state machine goes to IDLE and all counters clear. Reset mid-frame aborts the frame with no mdio_done pulse.
- States: IDLE, PREAMBLE, FRAME, DONE.
- IDLE accepts a request when mdio_start=1 and the frame is valid: t_data[31:30]==2'b01, and OP is 2'b01 (write) or 2'b10 (read).
- On acceptance: latch t_data, set busy=1 and mdio_oe=1 on the next clk edge, and go to PREAMBLE.
- Invalid ST or OP: the request is dropped. busy stays 0, there is no MDC activity and no mdio_done.
- mdio_start while busy is ignored.
- MDC generation: a divider counts 0..CLK_DIV-1 and toggles mdc at the terminal count. mdc idles low. MDC is active only in PREAMBLE and FRAME.
  - rise_tick = counter terminal while mdc=0.
  - fall_tick = counter terminal while mdc=1.
- Launch: mdio_out updates on the clk edge coinciding with each fall_tick, so bits are stable at every MDC rise. The first bit is presented at the start of the first MDC low phase.
- PREAMBLE: mdio_out=1 for PREAMBLE_LEN MDC periods, then go to FRAME with bit index 31.
- FRAME: shifts out latched bits 31 down to 0, one per MDC period.
  - Write: oe stays 1 for all 32 bits, and TA is driven from t_data[17:16].
  - Read: mdio_oe falls to 0 at the launch of bit 17 (first TA bit) and stays 0 through bit 0; mdio_out is held 0 while oe=0.
  - Read capture: mdio_in is sampled on rise_tick for bits 15..0 and shifted MSB-first into an internal shift register.
- DONE is entered after the final bit's MDC high phase completes (fall_tick after bit 0).
  - mdc returns low and oe returns to 0.
  - For reads, rd_data is loaded with the shift register; for writes, rd_data keeps its previous value.
  - mdio_done=1 for exactly one clk cycle, and busy drops in the same cycle.
  - Next state is IDLE. A new mdio_start is accepted one cycle after DONE.
- Latency: (PREAMBLE_LEN+32)*2*CLK_DIV clk from acceptance to mdio_done, ±1 clk for registration. With the defaults this is 256 clk.
- CLK_DIV=1 must work, giving an MDC half-period of 1 clk.

Decomposition:
- Package mdio_pkg holds:
  - ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10;
  - field offsets/widths (ST_MSB=31, OP_MSB=29, PHYAD_MSB=27, REGAD_MSB=22, TA_MSB=17, DATA_MSB=15);
  - FRAME_BITS=32;
  - the state encoding.
  The controller block reuses this package.
- Sub-module mdc_gen holds the divider with parameter CLK_DIV. It takes an enable input and outputs mdc, rise_tick and fall_tick.

Test Plan:
- Reset mid-frame: assert reset during PREAMBLE, then release → every output is 0 within the same cycle; a following start of 0x508AABCD completes normally.
- Write PHY 1, REG 2, data 0xABCD (t_data=0x508AABCD, CLK_DIV=2):
  - 32 ones are sent, then the bitstream 0101_00001_00010_10_1010101111001101 is sampled on MDC rises;
  - mdio_oe stays 1 throughout;
  - mdio_done pulses once ~256 clk after start.
- Read PHY 1, REG 2 (t_data=0x60880000) against a bench PHY model driving 0xFEED:
  - oe falls at the first TA bit;
  - rd_data=0xFEED when mdio_done pulses;
  - busy stays 1 until that pulse.
- Invalid frames rejected: t_data=0x708AABCD (OP=11) and t_data=0x108AABCD (ST=00) → busy stays 0, mdc stays low, no mdio_done.
- Back-to-back and ignored start:
  - start a read of 0xCAFE, then pulse mdio_start mid-frame → ignored, only one frame is sent;
  - a start one cycle after mdio_done is accepted;
  - rd_data=0xCAFE holds through a following write.
- CLK_DIV=1 regression: the read returns 0xFFFF with the line pulled high; the MDC period is 2 clk and the total is 128 clk.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 definitions: frame field layout, opcodes and the
// initiator state encoding. Also imported by the PHY-side controller.
package mdio_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int ST_MSB     = 31;
    localparam int OP_MSB     = 29;
    localparam int PHYAD_MSB  = 27;
    localparam int REGAD_MSB  = 22;
    localparam int TA_MSB     = 17;
    localparam int DATA_MSB   = 15;
    localparam int FRAME_BITS = 32;

    typedef logic [1:0] mdio_state_t;

    localparam mdio_state_t S_IDLE     = 2'd0;
    localparam mdio_state_t S_PREAMBLE = 2'd1;
    localparam mdio_state_t S_FRAME    = 2'd2;
    localparam mdio_state_t S_DONE     = 2'd3;

    // A frame is only worth sending with the Clause 22 start code and a read/write opcode.
    function automatic logic frame_valid(input logic [FRAME_BITS-1:0] w);
        return (w[ST_MSB -: 2] == ST_CODE) &&
               ((w[OP_MSB -: 2] == OP_WRITE) || (w[OP_MSB -: 2] == OP_READ));
    endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: half-period of CLK_DIV clk cycles while enabled, parked low otherwise.
// rise_tick/fall_tick flag the clk edge on which mdc goes high/low.
module mdc_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic mdc,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;
    logic          terminal;

    assign terminal  = enable && (cnt_q == TERM);
    assign rise_tick = terminal && !mdc_q;
    assign fall_tick = terminal && mdc_q;
    assign mdc       = mdc_q;

    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!enable) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (terminal) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// MDIO station-management initiator: preamble plus one Clause 22 frame per request,
// releasing the line at turnaround on reads and capturing 16 data bits.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [15:0] rd_data,
    output logic        mdio_done,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int            PW        = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_LEN - 1);
    localparam logic [4:0]    TA_LAST   = 5'(TA_MSB);
    localparam logic [4:0]    DATA_LAST = 5'(DATA_MSB);

    mdio_state_t     state_q, state_d;
    logic [31:0]     frame_q, frame_d;
    logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
    logic [4:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     shift_q, shift_d;
    logic [15:0]     rd_q, rd_d;
    logic            out_q, out_d;
    logic            oe_q, oe_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [4:0]      next_idx;
    logic            mdc_en;
    logic            rise_tick;
    logic            fall_tick;
    logic            is_read;

    assign mdc_en  = (state_q == S_PREAMBLE) || (state_q == S_FRAME);
    assign is_read = (frame_q[OP_MSB -: 2] == OP_READ);

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk       (clk),
        .reset     (reset),
        .enable    (mdc_en),
        .mdc       (mdc),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Request handshake: mdio_start is a one-cycle strobe looked at only in IDLE;
    // busy covers acceptance through the mdio_done cycle, where it drops.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        pre_cnt_d = pre_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rd_d      = rd_q;
        out_d     = out_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        next_idx  = bit_idx_q - 5'd1;
        case (state_q)
            S_IDLE: begin
                if (mdio_start && frame_valid(t_data)) begin
                    frame_d   = t_data;
                    busy_d    = 1'b1;
                    oe_d      = 1'b1;
                    out_d     = 1'b1;
                    pre_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (fall_tick) begin
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d   = S_FRAME;
                        bit_idx_d = 5'(FRAME_BITS - 1);
                        out_d     = frame_q[FRAME_BITS-1];
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (rise_tick && is_read && (bit_idx_q <= DATA_LAST)) begin
                    shift_d = {shift_q[14:0], mdio_in};
                end
                // Every launch happens on an MDC fall so the bit is settled at the next rise.
                if (fall_tick) begin
                    if (bit_idx_q == 5'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                        if (is_read) begin
                            rd_d = shift_q;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        if (is_read && (next_idx <= TA_LAST)) begin
                            oe_d  = 1'b0;
                            out_d = 1'b0;
                        end else begin
                            out_d = frame_q[next_idx];
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            pre_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rd_q      <= '0;
            out_q     <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            pre_cnt_q <= pre_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rd_q      <= rd_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign mdio_out  = out_q;
    assign mdio_oe   = oe_q;
    assign rd_data   = rd_q;
    assign mdio_done = done_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
